irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Interrupt request controller: the source side of the CPU_10 interrupt handshake.
//  - Collects N_SRC external interrupt lines and latches rising edges as pending.
//  - Drives a single irq line into the CPU's EX_irq input.
//  - Completes each request when the CPU returns an acknowledge pulse (INTA_irq) and later an end-of-interrupt pulse.
//  - Reports the serviced source index to the CPU.
// PARAMETERS
//  N_SRC    4   number of interrupt sources, 2..16
//  ID_W     2   width of irq_id; must equal $clog2(N_SRC)
//  MASK_RST 0   reset value of the mask register (bit=1 -> source masked)
// PORTS
//  clk        in   1        system clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  src        in   N_SRC    raw asynchronous interrupt lines, active-high
//  mask_we    in   1        write enable for the mask register
//  mask_wdata in   N_SRC    new mask value
//  inta       in   1        acknowledge pulse from CPU (INTA_irq), one cycle
//  eoi        in   1        end-of-interrupt pulse from CPU, one cycle
//  irq        out  1        interrupt request to CPU (EX_irq)
//  irq_id     out  ID_W     index of the requested/in-service source
//  pending    out  N_SRC    pending register, readable status
//  busy       out  1        1 while a request is outstanding or in service
// BEHAVIOUR
//  Reset values (async, rst_n=0)
//  - irq=0, irq_id=0, pending=0, busy=0, mask=MASK_RST.
//  - Synchroniser and edge-history flops clear to 0.
//  - State=IDLE.
//  Input path
//  - Each src bit passes through a 2-flop synchroniser plus a history flop.
//  - edge[i] = sync2[i] & ~hist[i].
//  - edge[i] sets pending[i] on the next clock.
//  - Latency: src sampled high at edge k -> pending[i]=1 after edge k+2 -> irq=1 after edge k+3.
//  Pending and mask
//  - pending is set on edge regardless of mask; the mask gates only request generation.
//  - Set wins over clear when an edge and an inta-clear hit the same bit in the same cycle.
//  - Mask write takes effect the cycle after mask_we.
//  FSM states: IDLE, REQ, SERVICE (encoding from irq_pkg)
//  - IDLE: if (pending & ~mask) != 0 -> REQ.
//    - irq_id latches the lowest-index unmasked pending bit (fixed priority, bit 0 highest).
//  - REQ: irq=1 and irq_id frozen.
//    - Mask changes do not withdraw the request.
//    - On inta: pending[irq_id] cleared, irq=0 next cycle -> SERVICE.
//  - SERVICE: irq=0, irq_id held, no new request issued (no nesting).
//    - On eoi -> IDLE; the next request may follow one cycle later.
//  - busy = (state != IDLE).
//  Ignored pulses
//  - inta outside REQ and eoi outside SERVICE are ignored.
//  - inta and eoi asserted together in REQ: inta honoured, eoi dropped.
//  Mid-operation reset
//  - rst_n low in any state forces IDLE immediately.
//  - Pending edges are lost.
//  - irq deasserts asynchronously.
// STRUCTURE
//  irq_pkg
//  - irq_state_t enum {IDLE, REQ, SERVICE}.
//  - Default N_SRC and ID_W constants.
//  - Function prio_enc(): lowest-set-bit index.
//  Sub-module irq_sync_edge: per-bit 2-flop synchroniser + rising-edge pulse, instanced N_SRC times.
//  Top level holds the mask, pending, FSM and priority encoder.
// TESTING
//  1. Reset release, src=0 for 20 cycles -> irq=0, busy=0, pending=4'b0000.
//  2. src[2] 0->1 held -> pending=4'b0100 at k+2, irq=1 with irq_id=2 at k+3.
//     - inta pulse -> irq=0, pending=0, busy=1.
//     - eoi pulse -> busy=0.
//  3. src[3] and src[1] rise in the same cycle -> irq_id=1 first.
//     - After inta+eoi -> second request with irq_id=3.
//  4. mask=4'b0010, src[1] rises -> pending=4'b0010, irq stays 0.
//     - Write mask=0 -> irq=1 with irq_id=1 two cycles after mask_we.
//  5. During SERVICE, src[0] rises -> pending[0]=1, no irq until eoi.
//     - After eoi -> irq_id=0 request.
//     - Stray inta in IDLE has no effect.
//  6. Assert rst_n=0 while in REQ -> irq=0 immediately, pending=0, FSM=IDLE.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt request controller.
// Holds the FSM encoding, default sizing and the fixed-priority encoder.
package irq_pkg;

  localparam int N_SRC_DEF = 4;
  localparam int ID_W_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  // Index of the lowest set bit; bit 0 has the highest priority.
  function automatic logic [3:0] prio_enc(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Signal bundle between the interrupt controller and its CPU-side user.
// The master drives sources, mask writes and the inta/eoi pulses.
interface irq_ctrl_if #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
);
  logic [N_SRC-1:0] src;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic             inta;
  logic             eoi;
  logic             irq;
  logic [ID_W-1:0]  irq_id;
  logic [N_SRC-1:0] pending;
  logic             busy;

  modport master (
    output src, mask_we, mask_wdata, inta, eoi,
    input  irq, irq_id, pending, busy
  );

  modport slave (
    input  src, mask_we, mask_wdata, inta, eoi,
    output irq, irq_id, pending, busy
  );
endinterface

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous interrupt line, followed by a
// history flop that turns the synchronised level into a one-cycle rising-edge pulse.
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_src,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist;

  // NOTE: non-blocking assignments let the three flops shift as a true pipeline;
  // blocking ones would collapse the chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= i_src;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign o_edge = r_sync2 & ~r_hist;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt request controller: latches source edges as pending, masks them,
// and runs a single-outstanding-request handshake (irq -> inta -> eoi) with the CPU.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int               N_SRC    = N_SRC_DEF,
  parameter int               ID_W     = ID_W_DEF,
  parameter logic [N_SRC-1:0] MASK_RST = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  irq_ctrl_if.slave   bus
);

  irq_state_t       r_state;
  irq_state_t       w_state_nxt;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_pending;
  logic [ID_W-1:0]  r_irq_id;
  logic [N_SRC-1:0] w_edge;
  logic [N_SRC-1:0] w_req;
  logic [N_SRC-1:0] w_clr;
  logic             w_take;
  logic             w_irq;
  logic             w_busy;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_src  (bus.src[g]),
      .o_edge (w_edge[g])
    );
  end

  assign w_req  = r_pending & ~r_mask;
  assign w_take = (r_state == REQ) && bus.inta;
  assign w_clr  = w_take ? (N_SRC'(1) << r_irq_id) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask    <= MASK_RST;
      r_pending <= '0;
    end else begin
      if (bus.mask_we) r_mask <= bus.mask_wdata;
      // A fresh edge on the bit being acknowledged survives the clear.
      r_pending <= (r_pending & ~w_clr) | w_edge;
    end
  end

  // The id is captured only when a request is issued, so it stays frozen
  // through REQ and SERVICE regardless of later pending or mask changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_id <= '0;
    end else if (r_state == IDLE && |w_req) begin
      r_irq_id <= ID_W'(prio_enc(16'(w_req)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: defaulting the next state before the case keeps every path assigned,
  // so no latch is inferred for states that simply hold.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (|w_req)   w_state_nxt = REQ;
      REQ:     if (bus.inta) w_state_nxt = SERVICE;
      SERVICE: if (bus.eoi)  w_state_nxt = IDLE;
      default:               w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_irq  = (r_state == REQ);
    w_busy = (r_state != IDLE);
  end

  assign bus.irq     = w_irq;
  assign bus.busy    = w_busy;
  assign bus.irq_id  = r_irq_id;
  assign bus.pending = r_pending;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed handshake scenarios plus randomized
// traffic, all compared every cycle against a sample-history reference model.
module tb_irq_ctrl;

  typedef enum {M_IDLE, M_REQ, M_SVC} m_state_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  irq_ctrl_if #(.N_SRC(4), .ID_W(2)) bus ();

  irq_ctrl #(.N_SRC(4), .ID_W(2), .MASK_RST(4'b0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: h[0..2] are src as sampled at the last three clock edges.
  logic [3:0] h [3];
  logic [3:0] m_pending;
  logic [3:0] m_mask;
  logic [1:0] m_id;
  m_state_t   m_state;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) h[i] = 4'b0;
    m_pending = 4'b0;
    m_mask    = 4'b0;
    m_id      = 2'd0;
    m_state   = M_IDLE;
  endtask

  // A source seen high two edges ago but low three edges ago becomes pending now.
  task automatic model_step();
    logic [3:0] ev, req, clr;
    ev  = h[1] & ~h[2];
    req = m_pending & ~m_mask;
    clr = 4'b0;
    case (m_state)
      M_IDLE: if (req != 0) begin m_state = M_REQ; m_id = lowest(req); end
      M_REQ:  if (bus.inta) begin clr[m_id] = 1'b1; m_state = M_SVC; end
      M_SVC:  if (bus.eoi) m_state = M_IDLE;
      default: m_state = M_IDLE;
    endcase
    m_pending = (m_pending & ~clr) | ev;
    if (bus.mask_we) m_mask = bus.mask_wdata;
    h[2] = h[1];
    h[1] = h[0];
    h[0] = bus.src;
  endtask

  task automatic compare_all();
    check("irq",     32'(bus.irq),     32'(m_state == M_REQ));
    check("busy",    32'(bus.busy),    32'(m_state != M_IDLE));
    check("pending", 32'(bus.pending), 32'(m_pending));
    check("irq_id",  32'(bus.irq_id),  32'(m_id));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_inta();
    bus.inta = 1'b1; cycle(); bus.inta = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.eoi = 1'b1; cycle(); bus.eoi = 1'b0;
  endtask

  task automatic wait_irq(input string tag, input int max);
    int n = 0;
    while (!bus.irq && n < max) begin cycle(); n++; end
    check(tag, 32'(bus.irq), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    rst_n = 1'b0;
    bus.src = 4'b0; bus.mask_we = 1'b0; bus.mask_wdata = 4'b0;
    bus.inta = 1'b0; bus.eoi = 1'b0;
    model_reset();
    cycles(3);
    rst_n = 1'b1;

    // 1: idle after reset
    cycles(20);
    check("t1_irq", 32'(bus.irq), 32'd0);
    check("t1_pending", 32'(bus.pending), 32'd0);

    // 2: single source, exact latency, full handshake
    bus.src = 4'b0100;
    cycles(3);
    check("t2_pend_k2", 32'(bus.pending), 32'b0100);
    check("t2_irq_k2", 32'(bus.irq), 32'd0);
    cycle();
    check("t2_irq_k3", 32'(bus.irq), 32'd1);
    check("t2_id", 32'(bus.irq_id), 32'd2);
    pulse_inta();
    check("t2_irq_ack", 32'(bus.irq), 32'd0);
    check("t2_pend_ack", 32'(bus.pending), 32'd0);
    check("t2_busy_ack", 32'(bus.busy), 32'd1);
    cycles(2);
    pulse_eoi();
    check("t2_busy_eoi", 32'(bus.busy), 32'd0);
    bus.src = 4'b0;
    cycles(4);

    // 3: simultaneous edges resolve by priority
    bus.src = 4'b1010;
    wait_irq("t3_irq_a", 10);
    check("t3_id_a", 32'(bus.irq_id), 32'd1);
    pulse_inta();
    pulse_eoi();
    wait_irq("t3_irq_b", 10);
    check("t3_id_b", 32'(bus.irq_id), 32'd3);
    pulse_inta();
    pulse_eoi();
    bus.src = 4'b0;
    cycles(4);

    // 4: masked source stays pending until unmasked
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b0010;
    cycle();
    bus.mask_we = 1'b0;
    bus.src = 4'b0010;
    cycles(6);
    check("t4_pend", 32'(bus.pending), 32'b0010);
    check("t4_irq_masked", 32'(bus.irq), 32'd0);
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b0000;
    cycle();
    bus.mask_we = 1'b0;
    check("t4_irq_m1", 32'(bus.irq), 32'd0);
    cycle();
    check("t4_irq_m2", 32'(bus.irq), 32'd1);
    check("t4_id", 32'(bus.irq_id), 32'd1);
    pulse_inta();
    pulse_eoi();
    bus.src = 4'b0;
    cycles(4);

    // 5: no nesting during SERVICE, stray inta in IDLE
    bus.src = 4'b0100;
    wait_irq("t5_irq_a", 10);
    pulse_inta();
    bus.src = 4'b0101;
    cycles(6);
    check("t5_pend_svc", 32'(bus.pending), 32'b0001);
    check("t5_irq_svc", 32'(bus.irq), 32'd0);
    pulse_eoi();
    wait_irq("t5_irq_b", 4);
    check("t5_id_b", 32'(bus.irq_id), 32'd0);
    pulse_inta();
    pulse_eoi();
    pulse_inta();
    check("t5_stray_busy", 32'(bus.busy), 32'd0);
    check("t5_stray_pend", 32'(bus.pending), 32'd0);
    bus.src = 4'b0;
    cycles(4);

    // 6: asynchronous reset while a request is outstanding
    bus.src = 4'b1000;
    wait_irq("t6_irq", 10);
    rst_n = 1'b0;
    #1;
    check("t6_irq_async", 32'(bus.irq), 32'd0);
    check("t6_pend_async", 32'(bus.pending), 32'd0);
    check("t6_busy_async", 32'(bus.busy), 32'd0);
    model_reset();
    bus.src = 4'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(4);

    // Randomized traffic, CPU behaviour driven from the model's view
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) bus.src = bus.src ^ (4'b1 << $urandom_range(0, 3));
      bus.mask_we    = ($urandom_range(0, 31) == 0);
      bus.mask_wdata = 4'($urandom_range(0, 15));
      bus.inta = (m_state == M_REQ) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      bus.eoi  = (m_state == M_SVC) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      cycle();
    end
    bus.inta = 1'b0; bus.eoi = 1'b0; bus.mask_we = 1'b0;
    cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
